// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

endpackage

// File: rtl/rr_arbiter_4_dec.sv
// 2-to-4 one-hot decoder with enable; all-zero output when disabled.
module rr_arbiter_4_dec (
    input  logic       a1,
    input  logic       a0,
    input  logic       en,
    output logic [3:0] y
);

    // Decode {a1,a0} to a single set bit, gated by en.
    always_comb begin
        y = '0;
        if (en) begin
            y[{a1, a0}] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with optional maximum-hold timeout.
// Grant is a registered index decoded to one-hot, so req never reaches gnt
// combinationally, and a one-cycle bubble separates consecutive tenures.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    // MAX_HOLD=0 wraps to all-ones here: the counter just saturates at its top.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;

    // Rotating-priority search: first requester after the last one granted.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = last_q + IDX_W'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        last_d      = last_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        unique case (state_q)
            IDLE: begin
                gnt_valid_d = 1'b0;
                if (en && win_found) begin
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q
                                                       : hold_cnt_q + CNT_W'(1);
                // Voluntary release takes precedence, so timeout stays low
                // when both causes land on the same edge.
                if (!req[gnt_idx_q]) begin
                    gnt_valid_d = 1'b0;
                    last_d      = gnt_idx_q;
                    state_d     = IDLE;
                end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
                    gnt_valid_d = 1'b0;
                    last_d      = gnt_idx_q;
                    timeout_d   = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; last resets to 3 so requester 0 goes first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_idx_q   <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            last_q      <= last_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    rr_arbiter_4_dec u_dec (
        .a1 (gnt_idx_q[1]),
        .a0 (gnt_idx_q[0]),
        .en (gnt_valid_q),
        .y  (gnt)
    );

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed scoreboard bench for rr_arbiter_4 with MAX_HOLD=8.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        logic       v;
        logic [1:0] idx;
        logic       to;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    rr_arbiter_4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_out(input logic v, input logic [1:0] idx, input logic to,
                              input string tag);
        exp_q.push_back('{v, idx, to, tag});
    endtask

    task automatic check_out();
        exp_t       e;
        logic [3:0] exp_gnt;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard: queue empty, nothing to compare");
        end else begin
            e       = exp_q.pop_front();
            exp_gnt = e.v ? (4'b0001 << e.idx) : 4'b0000;
            assert (gnt === exp_gnt && gnt_idx === e.idx && gnt_valid === e.v &&
                    timeout === e.to)
            else begin
                errors++;
                $error("FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, expected gnt=%b idx=%0d valid=%b timeout=%b",
                       e.tag, gnt, gnt_idx, gnt_valid, timeout,
                       exp_gnt, e.idx, e.v, e.to);
            end
        end
    endtask

    // Drive inputs, queue expected outputs after the next edge, then compare.
    task automatic step(input logic [3:0] r, input logic e, input logic v,
                        input logic [1:0] idx, input logic to, input string tag);
        req = r;
        en  = e;
        expect_out(v, idx, to, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        #12;
        expect_out(1'b0, 2'd0, 1'b0, "reset");
        check_out();
        rst = 1'b0;

        // 1: single requester, 1-cycle latency, release on req drop
        step(4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, "t1_grant0");
        step(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, "t1_release");

        // 2: all requesting, each holds two cycles; order 1,2,3,0 with bubbles
        step(4'b1111, 1'b1, 1'b1, 2'd1, 1'b0, "t2_g1a");
        step(4'b1111, 1'b1, 1'b1, 2'd1, 1'b0, "t2_g1b");
        step(4'b1101, 1'b1, 1'b0, 2'd1, 1'b0, "t2_bub1");
        step(4'b1101, 1'b1, 1'b1, 2'd2, 1'b0, "t2_g2a");
        step(4'b1101, 1'b1, 1'b1, 2'd2, 1'b0, "t2_g2b");
        step(4'b1001, 1'b1, 1'b0, 2'd2, 1'b0, "t2_bub2");
        step(4'b1001, 1'b1, 1'b1, 2'd3, 1'b0, "t2_g3a");
        step(4'b1001, 1'b1, 1'b1, 2'd3, 1'b0, "t2_g3b");
        step(4'b0001, 1'b1, 1'b0, 2'd3, 1'b0, "t2_bub3");
        step(4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, "t2_g0a");
        step(4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, "t2_g0b");
        step(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, "t2_rel0");

        // 3: lone requester held -> 8 grant cycles, timeout, bubble, re-grant
        for (int k = 0; k < 8; k++)
            step(4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, "t3_hold");
        step(4'b0100, 1'b1, 1'b0, 2'd2, 1'b1, "t3_timeout");
        step(4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, "t3_regrant");
        step(4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, "t3_release");

        // 4: req=0110, index 1 first, timeout hands over to index 2
        for (int k = 0; k < 8; k++)
            step(4'b0110, 1'b1, 1'b1, 2'd1, 1'b0, "t4_hold1");
        step(4'b0110, 1'b1, 1'b0, 2'd1, 1'b1, "t4_timeout");
        step(4'b0110, 1'b1, 1'b1, 2'd2, 1'b0, "t4_next2");
        step(4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, "t4_release");

        // Voluntary release on the hold-limit edge: no timeout pulse
        for (int k = 0; k < 8; k++)
            step(4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, "tc_hold0");
        step(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, "tc_coincide");

        // 5: en blocks new grants but not a running tenure
        step(4'b1010, 1'b0, 1'b0, 2'd0, 1'b0, "t5_blocked_a");
        step(4'b1010, 1'b0, 1'b0, 2'd0, 1'b0, "t5_blocked_b");
        step(4'b1010, 1'b1, 1'b1, 2'd1, 1'b0, "t5_grant1");
        for (int k = 0; k < 3; k++)
            step(4'b1010, 1'b0, 1'b1, 2'd1, 1'b0, "t5_en_low_hold");
        step(4'b1000, 1'b0, 1'b0, 2'd1, 1'b0, "t5_release");
        step(4'b1000, 1'b0, 1'b0, 2'd1, 1'b0, "t5_idle_en0");

        // 6: asynchronous reset in the middle of a tenure
        step(4'b1000, 1'b1, 1'b1, 2'd3, 1'b0, "t6_grant3a");
        step(4'b1000, 1'b1, 1'b1, 2'd3, 1'b0, "t6_grant3b");
        #2;
        req = 4'b1001;
        rst = 1'b1;
        #1;
        expect_out(1'b0, 2'd0, 1'b0, "t6_async_rst");
        check_out();
        @(posedge clk);
        #1;
        expect_out(1'b0, 2'd0, 1'b0, "t6_rst_held");
        check_out();
        rst = 1'b0;
        step(4'b1001, 1'b1, 1'b1, 2'd0, 1'b0, "t6_first0");
        step(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, "t6_release");

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
